// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - two-port round-robin access arbiter/sequencer for a one-bit-cell register file
// Optional bus-lock arbitration enabled by defining REGFILE_ARB_LOCK_EN.
module regfile_access_arbiter #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_wdata,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic              req0_lock,
    input  logic              req1_lock,
`endif
    output logic              rsp0_valid,
    output logic [WIDTH-1:0]  rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp1_rdata,
    output logic              rsp1_err,
    output logic [DEPTH-1:0]  rf_sel,
    output logic              rf_read,
    output logic              rf_write,
    output logic [WIDTH-1:0]  rf_wdata,
    input  logic [WIDTH-1:0]  rf_rdata
);

    // last_grant: 1 means port 1 was granted most recently
    logic              last_grant;
    logic              elig0, elig1;
    logic              accept, acc_port, acc_we, acc_err;
    logic [ADDR_W-1:0] acc_addr;
    logic [WIDTH-1:0]  acc_wdata;
    logic [DEPTH-1:0]  sel_next;

    logic              iss_port, iss_err;
    logic              cap_valid, cap_port, cap_err;

`ifdef REGFILE_ARB_LOCK_EN
    logic owner_valid, owner;
    logic acc_lock;

    assign elig0    = req0_valid && (!owner_valid || !owner);
    assign elig1    = req1_valid && (!owner_valid || owner);
    assign acc_lock = acc_port ? req1_lock : req0_lock;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_valid <= 1'b0;
            owner       <= 1'b0;
        end else if (accept) begin
            if (acc_lock) begin
                owner_valid <= 1'b1;
                owner       <= acc_port;
            end else begin
                // only the owner can be granted while locked, so this ends the sequence
                owner_valid <= 1'b0;
            end
        end
    end
`else
    assign elig0 = req0_valid;
    assign elig1 = req1_valid;
`endif

    assign req0_ready = elig0 && (!elig1 || last_grant);
    assign req1_ready = elig1 && (!elig0 || !last_grant);

    assign accept    = req0_ready || req1_ready;
    assign acc_port  = req1_ready;
    assign acc_we    = acc_port ? req1_we    : req0_we;
    assign acc_addr  = acc_port ? req1_addr  : req0_addr;
    assign acc_wdata = acc_port ? req1_wdata : req0_wdata;
    assign acc_err   = 32'(acc_addr) >= DEPTH;

    always_comb begin
        sel_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && !acc_err && (acc_addr == ADDR_W'(i))) begin
                sel_next[i] = 1'b1;
            end
        end
    end

    // Issue stage: drive the array strobes the cycle after accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rf_sel     <= '0;
            rf_read    <= 1'b0;
            rf_write   <= 1'b0;
            rf_wdata   <= '0;
            iss_port   <= 1'b0;
            iss_err    <= 1'b0;
        end else begin
            rf_sel   <= sel_next;
            rf_read  <= accept && !acc_we;
            rf_write <= accept && acc_we;
            if (accept) begin
                last_grant <= acc_port;
                rf_wdata   <= acc_wdata;
                iss_port   <= acc_port;
                iss_err    <= acc_err;
            end
        end
    end

    // Wait stage: tracks the read whose data the array presents this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_valid <= 1'b0;
            cap_port  <= 1'b0;
            cap_err   <= 1'b0;
        end else begin
            cap_valid <= rf_read;
            cap_port  <= iss_port;
            cap_err   <= iss_err;
        end
    end

    // Capture stage: rf_rdata is only sampled here, so unselected X never escapes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= cap_valid && !cap_port;
            rsp1_valid <= cap_valid && cap_port;
            if (cap_valid && !cap_port) begin
                rsp0_rdata <= cap_err ? '0 : rf_rdata;
                rsp0_err   <= cap_err;
            end
            if (cap_valid && cap_port) begin
                rsp1_rdata <= cap_err ? '0 : rf_rdata;
                rsp1_err   <= cap_err;
            end
        end
    end

endmodule

// File: doc/regfile_access_arbiter.md
# regfile_access_arbiter

Two-port access arbiter and sequencer for the generic register file built from one-bit memory cells. It accepts read/write requests from two independent requesters over valid/ready handshakes and grants one request per cycle in round-robin order. It drives the register file's row select, read and write strobes and write data, then returns read data to the originating port. It sits between the register file array and its two clients, such as a core datapath and a debug/DMA port.

## Interface
Parameters:
- DEPTH, 8: number of register rows.
- WIDTH, 8: bits per row (cells per row).
- ADDR_W, 3: request address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset_n  in  1  reset. Asynchronous, active-low.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  grant. Combinational from the valids and arbiter state.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  row address.
- req0_wdata / req1_wdata  in  WIDTH  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle read response strobe.
- rsp0_rdata / rsp1_rdata  out  WIDTH  read data. Holds its value between responses.
- rsp0_err / rsp1_err  out  1  out-of-range address flag, qualified by rspN_valid.
- rf_sel  out  DEPTH  one-hot row select to the cells.
- rf_read, rf_write  out  1  read / write strobes, common to all cells.
- rf_wdata  out  WIDTH  write data to all cells.
- rf_rdata  in  WIDTH  selected row's cell outputs. Valid the cycle after a read strobe; X otherwise.

## Operation
Arbitration:
- A request is accepted in a cycle where reqN_valid and reqN_ready are both 1.
- At most one request is accepted per cycle, so at most one reqN_ready is high.
- A single valid port is granted immediately.
- When both ports are valid, the grant goes to the port not granted most recently.
- The last-grant register updates only on an accept. After reset it equals 1, so port 0 wins the first tie.
- No backpressure on responses; a port must accept rspN_valid whenever it is asserted.

Issue stage (registered, cycle after accept):
- rf_sel = one-hot(addr) if addr < DEPTH, otherwise all zero.
- rf_read = ~we; rf_write = we; rf_wdata = wdata.
- The stage also records port id, read flag and err = (addr >= DEPTH).
- In a cycle with no accept, the stage drives rf_sel = 0, rf_read = 0, rf_write = 0. rf_wdata holds its previous value.

Capture stage (registered, cycle after issue, reads only):
- rspP_rdata <= rf_rdata, or all zero if err.
- rspP_err <= err; rspP_valid = 1 for exactly one cycle, where P is the recorded port.
- The other port's response outputs hold.
- rf_rdata is sampled only in this stage, so X values from unselected or non-read cells never reach rsp outputs.

Writes produce no response. Out-of-range writes are accepted and discarded, since no row is selected.

## Timing
- Write accepted in cycle T: strobes in T+1, row updated at the edge ending T+1.
- Read accepted in cycle T: strobes in T+1, rf_rdata valid in T+2, rspN_valid in T+3. Latency is 3 cycles.
- Throughput: one access per cycle sustained, with both ports interleaving under contention.
- A read accepted in T+1 of the same address as a write accepted in T returns the new data. No bypass logic is needed.
- Responses return in acceptance order. Both rsp valids are never high in the same cycle.
- Reset values: all rf_* outputs 0, rsp*_valid 0, rsp*_rdata 0, rsp*_err 0, last-grant = 1.
- Reset asserted mid-operation flushes both pipeline stages immediately; no response is produced for in-flight reads.
- Register contents after reset are undefined (cells reset to X). The arbiter performs no initialisation.

## Configuration
- REGFILE_ARB_LOCK_EN defined: adds inputs req0_lock and req1_lock (1 bit each).
  - Accepting a request with lock = 1 makes that port the lock owner.
  - While an owner exists, only the owner can be granted; the other port's ready stays 0 even if the owner is idle.
  - The owner is cleared when it is granted a request with lock = 0, and that request completes the sequence.
  - The last-grant register still updates normally.
  - Reset clears the owner.
- REGFILE_ARB_LOCK_EN undefined: the lock ports are absent and arbitration is pure round-robin.

## Test plan
- Reset, then port 0 writes addr 2 = 0xA5 and later reads addr 2 → rf_sel = 0x04 with rf_write for one cycle; rsp0_valid three cycles after the read accept, rsp0_rdata = 0xA5, rsp0_err = 0.
- Both ports hold valid reads continuously (addrs 1 and 3, preloaded 0x11 and 0x33) → grants alternate starting with port 0; responses alternate 0x11 on port 0 and 0x33 on port 1, one per cycle, never both valid together.
- Port 1 writes addr 5 = 0x3C, and port 0 reads addr 5 in the very next cycle → rsp0_rdata = 0x3C.
- Port 0 reads addr 9 with DEPTH = 8, ADDR_W = 4 → rf_sel = 0; rsp0_valid with rsp0_rdata = 0x00 and rsp0_err = 1. A write to addr 9 alters no row.
- Reset pulsed one cycle after a read accept → no rspN_valid afterwards and all outputs at reset values. With REGFILE_ARB_LOCK_EN: port 1 issues read(lock=1), write(lock=0) while port 0 is valid throughout → port 0 ready stays 0 until the unlocked write is accepted, then port 0 is granted.
